// File: rtl/tdm_demux_8_if.sv
// Bus between the TDM serial sender and the 8-lane receive demultiplexer.
// The sender drives the serial word stream; the receiver returns the assembled frame and status.
interface tdm_demux_8_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]   din;
  logic               din_valid;
  logic               sof;
  logic [8*WIDTH-1:0] dout;
  logic               frame_valid;
  logic               sync_err;
  logic [2:0]         cur_lane;

  modport master (
    output din, din_valid, sof,
    input  dout, frame_valid, sync_err, cur_lane
  );

  modport slave (
    input  din, din_valid, sof,
    output dout, frame_valid, sync_err, cur_lane
  );
endinterface

// File: rtl/tdm_demux_8.sv
// 8-lane TDM receive demultiplexer: stages lanes 0..6, then publishes the whole frame
// on the cycle lane 7 arrives. Reports framing errors and resynchronises on sof.
module tdm_lane_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module tdm_demux_8 #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux_8_if.slave bus
);
  localparam int STAGED = 7;

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t                             r_state;
  logic [2:0]                         r_cnt;
  logic [8*WIDTH-1:0]                 r_dout;
  logic                               r_frame_valid;
  logic                               r_sync_err;
  logic [STAGED-1:0]                  w_we;
  logic [STAGED-1:0][WIDTH-1:0]       w_stage;

  // Lane 7 is never staged: it goes straight from din into dout with lanes 0..6.
  for (genvar n = 0; n < STAGED; n++) begin : g_lane
    assign w_we[n] = bus.din_valid &
                     (bus.sof ? (n == 0) : (r_state == COLLECT && r_cnt == 3'(n)));

    tdm_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_we[n]),
      .i_d   (bus.din),
      .o_q   (w_stage[n])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= HUNT;
      r_cnt         <= 3'd0;
      r_dout        <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      case (r_state)
        HUNT: begin
          if (bus.din_valid) begin
            if (bus.sof) begin
              r_cnt   <= 3'd1;
              r_state <= COLLECT;
            end else begin
              r_sync_err <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (bus.din_valid) begin
            if (bus.sof) begin
              // Early sof: drop the partial frame and restart at lane 1.
              r_sync_err <= 1'b1;
              r_cnt      <= 3'd1;
            end else if (r_cnt == 3'd7) begin
              r_dout        <= {bus.din, w_stage};
              r_frame_valid <= 1'b1;
              r_cnt         <= 3'd0;
              r_state       <= HUNT;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        default: begin
          r_state <= HUNT;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.dout        = r_dout;
  assign bus.frame_valid = r_frame_valid;
  assign bus.sync_err    = r_sync_err;
  assign bus.cur_lane    = r_cnt;
endmodule

// File: tb/tb_tdm_demux_8.sv
// Directed bench for tdm_demux_8 with WIDTH=8 and hand-computed frames.
module tb_tdm_demux_8;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;
  int   fv_cnt = 0;
  int   se_cnt = 0;
  int   both_cnt = 0;
  int   fv0, se0;

  tdm_demux_8_if #(.WIDTH(W)) bus ();

  tdm_demux_8 #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulses last one full cycle, so each is seen at exactly one falling edge.
  always @(negedge clk) begin
    if (bus.frame_valid) fv_cnt++;
    if (bus.sync_err) se_cnt++;
    if (bus.frame_valid && bus.sync_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Present one word for one clock; returns 1 time unit after the sampling edge.
  task automatic word(input logic s, input logic [W-1:0] d);
    @(negedge clk);
    bus.din = d; bus.din_valid = 1'b1; bus.sof = s;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.din_valid = 1'b0; bus.sof = 1'b0; bus.din = 8'hEE;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.din_valid = 1'b0; bus.sof = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("rst_dout", bus.dout, 64'h0);
    chk("rst_lane", 64'(bus.cur_lane), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.din = '0; bus.din_valid = 1'b0; bus.sof = 1'b0;
    #12;
    chk("rst_dout", bus.dout, 64'h0);
    chk("rst_fv", 64'(bus.frame_valid), 64'h0);
    chk("rst_se", 64'(bus.sync_err), 64'h0);
    chk("rst_lane", 64'(bus.cur_lane), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contiguous frame 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      word(i == 0, 8'h10 + 8'(i));
      chk("seq_lane", 64'(bus.cur_lane), 64'((i + 1) % 8));
      if (i < 7) chk("seq_nofv", 64'(bus.frame_valid), 64'h0);
    end
    chk("seq_fv", 64'(bus.frame_valid), 64'h1);
    chk("seq_dout", bus.dout, 64'h1716151413121110);
    idle(1);
    chk("seq_fv_pulse", 64'(bus.frame_valid), 64'h0);
    chk("seq_fvcnt", 64'(fv_cnt), 64'd1);
    chk("seq_secnt", 64'(se_cnt), 64'd0);

    // Same frame with 3-cycle gaps between every word
    fv0 = fv_cnt;
    for (int i = 0; i < 8; i++) begin
      word(i == 0, 8'h10 + 8'(i));
      chk("gap_lane", 64'(bus.cur_lane), 64'((i + 1) % 8));
      if (i < 7) begin
        idle(3);
        chk("gap_hold", 64'(bus.cur_lane), 64'(i + 1));
      end
    end
    chk("gap_fv", 64'(bus.frame_valid), 64'h1);
    chk("gap_dout", bus.dout, 64'h1716151413121110);
    idle(1);
    chk("gap_fvcnt", 64'(fv_cnt - fv0), 64'd1);

    // Back-to-back frames A then B
    fv0 = fv_cnt;
    for (int i = 0; i < 8; i++) word(i == 0, 8'hA0 + 8'(i));
    chk("bb_fvA", 64'(bus.frame_valid), 64'h1);
    chk("bb_doutA", bus.dout, 64'hA7A6A5A4A3A2A1A0);
    for (int i = 0; i < 8; i++) begin
      word(i == 0, 8'hB0 + 8'(i));
      if (i < 7) chk("bb_doutA_hold", bus.dout, 64'hA7A6A5A4A3A2A1A0);
    end
    chk("bb_fvB", 64'(bus.frame_valid), 64'h1);
    chk("bb_doutB", bus.dout, 64'hB7B6B5B4B3B2B1B0);
    idle(1);
    chk("bb_fvcnt", 64'(fv_cnt - fv0), 64'd2);

    // Words without sof after reset
    do_reset();
    fv0 = fv_cnt; se0 = se_cnt;
    word(1'b0, 8'h55);
    chk("hunt_se1", 64'(bus.sync_err), 64'h1);
    chk("hunt_lane1", 64'(bus.cur_lane), 64'h0);
    word(1'b0, 8'h66);
    chk("hunt_se2", 64'(bus.sync_err), 64'h1);
    idle(1);
    chk("hunt_se_clr", 64'(bus.sync_err), 64'h0);
    chk("hunt_dout", bus.dout, 64'h0);
    chk("hunt_secnt", 64'(se_cnt - se0), 64'd2);
    chk("hunt_fvcnt", 64'(fv_cnt - fv0), 64'd0);

    // Resync on early sof
    se0 = se_cnt; fv0 = fv_cnt;
    word(1'b1, 8'h20); word(1'b0, 8'h21); word(1'b0, 8'h22);
    chk("rs_lane_pre", 64'(bus.cur_lane), 64'h3);
    word(1'b1, 8'h30);
    chk("rs_se", 64'(bus.sync_err), 64'h1);
    chk("rs_lane", 64'(bus.cur_lane), 64'h1);
    chk("rs_dout_keep", bus.dout, 64'h0);
    for (int i = 1; i < 8; i++) word(1'b0, 8'h30 + 8'(i));
    chk("rs_fv", 64'(bus.frame_valid), 64'h1);
    chk("rs_dout", bus.dout, 64'h3736353433323130);
    idle(1);
    chk("rs_secnt", 64'(se_cnt - se0), 64'd1);
    chk("rs_fvcnt", 64'(fv_cnt - fv0), 64'd1);

    // Reset mid-frame after lane 4, then a clean frame
    for (int i = 0; i < 5; i++) word(i == 0, 8'hD0 + 8'(i));
    chk("mr_lane", 64'(bus.cur_lane), 64'h5);
    do_reset();
    fv0 = fv_cnt;
    idle(1);
    chk("mr_fv_none", 64'(fv_cnt - fv0), 64'd0);
    for (int i = 0; i < 8; i++) word(i == 0, 8'hC0 + 8'(i));
    chk("mr_fv", 64'(bus.frame_valid), 64'h1);
    chk("mr_dout", bus.dout, 64'hC7C6C5C4C3C2C1C0);
    idle(2);
    chk("mr_fvcnt", 64'(fv_cnt - fv0), 64'd1);
    chk("never_both", 64'(both_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
